// File: rtl/pdm_audio_capture_pkg.sv
// Shared helpers for the PDM audio capture block.
package pdm_audio_capture_pkg;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pdm_audio_capture_chan_acc.sv
// Per-channel ones counter: latches the raw bit, accumulates, and captures the
// count into pcm at the window boundary.
module pdm_chan_acc #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sel,
  input  logic             din,
  input  logic             boundary,
  output logic             bit_out,
  output logic [CNT_W-1:0] pcm
);

  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] sum;

  // Running count including this edge's bit when this channel is sampled.
  assign sum = acc + CNT_W'(sel & din);

  // Accumulate, capture on the boundary and restart the window on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      pcm     <= '0;
      bit_out <= 1'b0;
    end else if (en) begin
      if (sel) begin
        bit_out <= din;
      end
      if (boundary) begin
        pcm <= sum;
        acc <= '0;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/pdm_audio_capture.sv
// Demultiplexes a slot-interleaved 1-bit audio stream into CHANNELS channels
// and decimates each by counting ones over DECIM frames.
module pdm_audio_capture
  import pdm_audio_capture_pkg::*;
#(
  parameter  int unsigned CHANNELS = 2,
  parameter  int unsigned DECIM    = 64,
  localparam int unsigned CNT_W    = $clog2(DECIM + 1),
  localparam int unsigned SLOT_W   = min1_clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      din,
  output logic [SLOT_W-1:0]         slot,
  output logic                      frame_start,
  output logic [CHANNELS-1:0]       bit_out,
  output logic [CHANNELS*CNT_W-1:0] pcm,
  output logic                      pcm_valid
);

  localparam int unsigned FRAME_W = min1_clog2(DECIM);

  logic [FRAME_W-1:0] frame_cnt;
  logic               last_slot;
  logic               last_frame;
  logic               boundary;

  // Window-end detection; boundary only fires on an enabled edge.
  assign last_slot   = (slot == SLOT_W'(CHANNELS - 1));
  assign last_frame  = (frame_cnt == FRAME_W'(DECIM - 1));
  assign boundary    = en & last_slot & last_frame;
  assign frame_start = en & (slot == '0);

  // Slot index wraps after the last channel of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (en) begin
      slot <= last_slot ? '0 : slot + SLOT_W'(1);
    end
  end

  // Frame counter advances once per completed frame and wraps per window.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (en && last_slot) begin
      frame_cnt <= last_frame ? '0 : frame_cnt + FRAME_W'(1);
    end
  end

  // One-cycle strobe following the edge that closes a window.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= boundary;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pdm_chan_acc #(
      .CNT_W(CNT_W)
    ) u_acc (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sel     (slot == SLOT_W'(c)),
      .din     (din),
      .boundary(boundary),
      .bit_out (bit_out[c]),
      .pcm     (pcm[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_pdm_audio_capture.sv
// Bench for pdm_audio_capture: three configurations (2x4, 3x1, 2x64) share one
// stimulus stream; a behavioural model per instance feeds a scoreboard queue.
module tb_pdm_audio_capture;

  logic clk;
  logic rst;
  logic en;
  logic din;

  logic       slot_a, fs_a, valid_a;
  logic [1:0] bit_a;
  logic [5:0] pcm_a;
  logic [1:0] slot_b;
  logic       fs_b, valid_b;
  logic [2:0] bit_b;
  logic [2:0] pcm_b;
  logic       slot_d, fs_d, valid_d;
  logic [1:0] bit_d;
  logic [13:0] pcm_d;

  pdm_audio_capture #(.CHANNELS(2), .DECIM(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .slot(slot_a),
    .frame_start(fs_a), .bit_out(bit_a), .pcm(pcm_a), .pcm_valid(valid_a));

  pdm_audio_capture #(.CHANNELS(3), .DECIM(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .slot(slot_b),
    .frame_start(fs_b), .bit_out(bit_b), .pcm(pcm_b), .pcm_valid(valid_b));

  pdm_audio_capture #(.CHANNELS(2), .DECIM(64)) u_dut_d (
    .clk(clk), .rst(rst), .en(en), .din(din), .slot(slot_d),
    .frame_start(fs_d), .bit_out(bit_d), .pcm(pcm_d), .pcm_valid(valid_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      inst;
    logic [2:0][7:0] pcm;
    logic [2:0]      bits;
  } exp_t;

  exp_t q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int m_ch[3]  = '{2, 3, 2};
  int m_dec[3] = '{4, 1, 64};
  int m_acc[3][3];
  int m_pcm[3][3];
  int m_bits[3][3];
  int m_slot[3];
  int m_frame[3];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int g_slot(input int k);
    case (k)
      0:       return int'(slot_a);
      1:       return int'(slot_b);
      default: return int'(slot_d);
    endcase
  endfunction

  function automatic int g_fs(input int k);
    case (k)
      0:       return int'(fs_a);
      1:       return int'(fs_b);
      default: return int'(fs_d);
    endcase
  endfunction

  function automatic int g_valid(input int k);
    case (k)
      0:       return int'(valid_a);
      1:       return int'(valid_b);
      default: return int'(valid_d);
    endcase
  endfunction

  function automatic int g_pcm(input int k, input int c);
    case (k)
      0:       return int'(pcm_a[c*3 +: 3]);
      1:       return int'(pcm_b[c +: 1]);
      default: return int'(pcm_d[c*7 +: 7]);
    endcase
  endfunction

  function automatic int g_bit(input int k, input int c);
    case (k)
      0:       return int'(bit_a[c]);
      1:       return int'(bit_b[c]);
      default: return int'(bit_d[c]);
    endcase
  endfunction

  // Compare every instance against the model just after an active edge.
  task automatic check_after_edge(input int ev0, input int ev1, input int ev2);
    int   ev[3];
    exp_t e;
    ev = '{ev0, ev1, ev2};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), g_valid(k), ev[k]);
      if (g_valid(k) == 1) begin
        if (q.size() == 0) begin
          chk($sformatf("sb_empty%0d", k), q.size(), 1);
        end else begin
          e = q.pop_front();
          chk($sformatf("sb_inst%0d", k), k, int'(e.inst));
          for (int c = 0; c < m_ch[k]; c++) begin
            chk($sformatf("sb_pcm%0d_%0d", k, c), g_pcm(k, c), int'(e.pcm[c]));
            chk($sformatf("sb_bit%0d_%0d", k, c), g_bit(k, c), int'(e.bits[c]));
          end
        end
      end
      for (int c = 0; c < m_ch[k]; c++) begin
        chk($sformatf("pcm%0d_%0d", k, c), g_pcm(k, c), m_pcm[k][c]);
        chk($sformatf("bit%0d_%0d", k, c), g_bit(k, c), m_bits[k][c]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      m_slot[k]  = 0;
      m_frame[k] = 0;
      for (int c = 0; c < 3; c++) begin
        m_acc[k][c]  = 0;
        m_pcm[k][c]  = 0;
        m_bits[k][c] = 0;
      end
      chk($sformatf("rst_slot%0d", k), g_slot(k), 0);
    end
    check_after_edge(0, 0, 0);
  endtask

  // Drive one cycle, advance the model, push expected samples, then check.
  task automatic step(input logic e, input logic d);
    int   ev[3];
    int   c;
    exp_t ent;
    @(negedge clk);
    rst = 1'b0;
    en  = e;
    din = d;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("slot%0d", k), g_slot(k), m_slot[k]);
      chk($sformatf("fs%0d", k), g_fs(k), (e && m_slot[k] == 0) ? 1 : 0);
      ev[k] = 0;
      if (e) begin
        c = m_slot[k];
        m_bits[k][c] = int'(d);
        m_acc[k][c] += int'(d);
        if (c == m_ch[k] - 1) begin
          m_slot[k] = 0;
          if (m_frame[k] == m_dec[k] - 1) begin
            m_frame[k] = 0;
            ev[k] = 1;
            ent = '0;
            ent.inst = 2'(k);
            for (int cc = 0; cc < m_ch[k]; cc++) begin
              ent.pcm[cc]  = 8'(m_acc[k][cc]);
              ent.bits[cc] = m_bits[k][cc][0];
              m_pcm[k][cc] = m_acc[k][cc];
              m_acc[k][cc] = 0;
            end
            q.push_back(ent);
          end else begin
            m_frame[k]++;
          end
        end else begin
          m_slot[k] = c + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_after_edge(ev[0], ev[1], ev[2]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int last_v;
    int nv;
    rst = 1'b1;
    en  = 1'b0;
    din = 1'b0;

    // All ones over one 2x4 window.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk("t1_ch0", g_pcm(0, 0), 4);
    chk("t1_ch1", g_pcm(0, 1), 4);
    chk("t1_bits", int'(bit_a), 3);

    // Alternating 1,0: ch0 sees every one, ch1 none, for two windows.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
      if (i == 7 || i == 15) begin
        chk("t2_valid", int'(valid_a), 1);
        chk("t2_ch0", g_pcm(0, 0), 4);
        chk("t2_ch1", g_pcm(0, 1), 0);
        chk("t2_bits", int'(bit_a), 1);
      end
    end

    // Enable gap mid-window; slot frozen at 1, din ignored.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("t3_gap_slot", int'(slot_a), 1);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("t3_ch0", g_pcm(0, 0), 4);
    chk("t3_ch1", g_pcm(0, 1), 4);

    // Reset mid-window discards the partial accumulation.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    chk("t4_hold_ch0", g_pcm(0, 0), 0);
    step(1'b1, 1'b1);
    chk("t4_ch0", g_pcm(0, 0), 4);
    chk("t4_ch1", g_pcm(0, 1), 4);

    // 3 channels, DECIM=1: a sample every frame.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, (i % 3 == 1) ? 1'b0 : 1'b1);
    chk("t5_valid", int'(valid_b), 1);
    chk("t5_pcm", int'(pcm_b), 3'b101);

    // 2x64 all ones: full-scale count of 64 without wrap, period 128.
    do_reset();
    last_v = -1;
    nv = 0;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b1);
      if (valid_d) begin
        nv++;
        if (last_v >= 0) chk("t6_period", cyc - last_v, 128);
        last_v = cyc;
        chk("t6_ch0", g_pcm(2, 0), 64);
        chk("t6_ch1", g_pcm(2, 1), 64);
      end
    end
    chk("t6_count", nv, 2);

    // Random enable and data.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end

    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pdm_audio_capture.md
Name: pdm_audio_capture

Overview:
- Parametrised successor to the simulation top's two-channel L/R audio demux.
- Takes the chip's single time-multiplexed 1-bit audio stream and splits it across CHANNELS interleaved slots.
- Decimates each channel's 1-bit PDM stream by counting ones over DECIM frames, producing per-channel PCM words for the testbench to dump to file.
- Sits in the sim wrapper between the chip's audio output pin and the bench's audio writer.

Parameters:
- CHANNELS, 2, number of interleaved slots per frame (>=1); slot 0 = first slot after reset (right channel for stereo, matching existing ordering).
- DECIM, 64, frames accumulated per PCM sample (>=1).
- Derived (localparam): CNT_W = $clog2(DECIM+1).
- Derived (localparam): SLOT_W = max(1, $clog2(CHANNELS)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- en  in  1  advance enable; when low all state holds.
- din  in  1  serial audio bit from chip, one slot per enabled cycle.
- slot  out  SLOT_W  index of slot sampled on the next enabled edge.
- frame_start  out  1  combinational: en & (slot==0).
- bit_out  out  CHANNELS  last raw bit per channel (generalised audiol/audior).
- pcm  out  CHANNELS*CNT_W  per-channel ones count; channel c at [c*CNT_W +: CNT_W].
- pcm_valid  out  1  one-cycle pulse when pcm updates.

Behaviour:
- Reset values: slot=0, frame_cnt=0, all acc=0, pcm=0, bit_out=0, pcm_valid=0.
- Reset mid-frame discards partial accumulation; no pcm_valid is emitted for the partial window.
- en=0: slot, frame_cnt, acc, bit_out and pcm hold; pcm_valid forced 0 that cycle.
- Each edge with en=1, s=slot:
  - bit_out[s] <= din; acc[s] <= acc[s] + din.
  - slot <= (s==CHANNELS-1) ? 0 : s+1.
  - If s==CHANNELS-1: frame_cnt <= (frame_cnt==DECIM-1) ? 0 : frame_cnt+1.
- Sample boundary (s==CHANNELS-1 and frame_cnt==DECIM-1, en=1):
  - pcm[c] <= acc[c] for c<CHANNELS-1.
  - pcm[CHANNELS-1] <= acc[CHANNELS-1] + din, so the current bit is included.
  - All acc cleared to 0 on the same edge, then resume from this edge with no dropped bit.
  - pcm_valid <= 1; otherwise pcm_valid <= 0.
- Latency: pcm_valid is high in the cycle immediately after the edge sampling the last bit of the window. A window is CHANNELS*DECIM enabled cycles.
- Width: acc and pcm are CNT_W unsigned. The maximum is DECIM, so no overflow and no saturation logic is needed.
- CHANNELS=1: slot constant 0, frame_start = en.
- DECIM=1: every frame is a sample boundary; frame_cnt is held at 0.
- Back-to-back windows: pcm_valid may be high in consecutive cycles only when CHANNELS=1 and DECIM=1.

Decomposition:
- Shared sim package: none required. CNT_W and SLOT_W stay localparams in the module.
- One natural sub-module: pdm_chan_acc (one instance per channel via generate). It holds the CNT_W accumulator, bit_out register, sample capture and clear, with inputs sel, bit, boundary, en.
- Top level holds the slot counter, frame counter and pcm_valid.

Test Plan:
1. CHANNELS=2, DECIM=4, din=1 from reset release for 8 cycles -> pcm_valid high only in cycle 8; pcm ch0=4, ch1=4; bit_out=2'b11.
2. CHANNELS=2, DECIM=4, din = 1,0,1,0... -> at cycle 8 ch0=4, ch1=0, bit_out=2'b01; second window identical at cycle 16.
3. Test 1 with en=0 for 3 cycles after cycle 3 -> slot frozen at 1 during the gap; pcm_valid at cycle 11; same pcm values; frame_start low during the gap.
4. Test 1 with rst asserted at cycle 5 for 1 cycle -> no pcm_valid before cycle 14; pcm reads 0 until then; cycle 14 values ch0=4, ch1=4.
5. CHANNELS=3, DECIM=1, din pattern 1,0,1 repeating -> pcm_valid every 3rd cycle; pcm {ch2,ch1,ch0}={1,0,1}; slot cycles 0,1,2.
6. CHANNELS=2, DECIM=64, din all ones -> pcm each = 64 (CNT_W=7, no wrap); pcm_valid period = 128 cycles.
